// File: rtl/adder_tree_feeder.sv
// Packs a serial stream of signed partial sums into an 8-lane operand bank for
// adder_tree and holds the bank until the consumer acknowledges it.
module adder_tree_feeder #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              use_adder_tree,
    output logic [DATA_W-1:0] operand_0,
    output logic [DATA_W-1:0] operand_1,
    output logic [DATA_W-1:0] operand_2,
    output logic [DATA_W-1:0] operand_3,
    output logic [DATA_W-1:0] operand_4,
    output logic [DATA_W-1:0] operand_5,
    output logic [DATA_W-1:0] operand_6,
    output logic [DATA_W-1:0] operand_7,
    output logic [3:0]        lane_cnt,
    output logic              state_dbg
);

    localparam int LANES = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    logic [2:0]        idx;
    logic [DATA_W-1:0] lanes [LANES];

    // Handshakes: a value moves on a rising edge where in_valid && in_ready (and no
    // clear); a bank is released on a rising edge where out_valid && out_ready.
    // Both ready/valid outputs are registered, so nothing combinational reaches them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            idx       <= '0;
            lane_cnt  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            for (int k = 0; k < LANES; k++) lanes[k] <= '0;
        end else if (clear) begin
            state     <= FILL;
            idx       <= '0;
            lane_cnt  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            for (int k = 0; k < LANES; k++) lanes[k] <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        lanes[idx] <= in_data;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7 || in_last) begin
                            state     <= HOLD;
                            lane_cnt  <= {1'b0, idx} + 4'd1;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    // Unused lanes must read back as zero for the next short group.
                    if (out_ready) begin
                        state     <= FILL;
                        idx       <= '0;
                        lane_cnt  <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        for (int k = 0; k < LANES; k++) lanes[k] <= '0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    assign use_adder_tree = out_valid;
    assign state_dbg      = state;
    assign operand_0      = lanes[0];
    assign operand_1      = lanes[1];
    assign operand_2      = lanes[2];
    assign operand_3      = lanes[3];
    assign operand_4      = lanes[4];
    assign operand_5      = lanes[5];
    assign operand_6      = lanes[6];
    assign operand_7      = lanes[7];

endmodule
